aes_ctrl_seq: RTL and testbench

- Top-level AES sequencing controller, directly upstream of the cipher-core control FSM.
- Tracks software writes to the data-in, key and trigger registers, and decides when to launch an encrypt/decrypt, a decryption-key generation, or a key/data clear.
- Drives the cipher-core in/out valid-ready handshakes and generates write enables for the data-in-previous and data-out registers.
- Owns the output-valid/stall status seen by software.

---
 rtl/aes_ctrl_seq_if.sv | 34 +++
 rtl/aes_ctrl_seq.sv | 179 +++++++++++++++++
 tb/tb_aes_ctrl_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_seq_if.sv
// Valid/ready request and response channel between the AES sequencing
// controller (master) and the cipher-core control FSM (slave).
interface aes_ctrl_seq_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic start;
  logic dec_key_gen;
  logic key_clear;
  logic data_out_clear;

  modport master (
    output in_valid,
    output out_ready,
    output start,
    output dec_key_gen,
    output key_clear,
    output data_out_clear,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    input  start,
    input  dec_key_gen,
    input  key_clear,
    input  data_out_clear,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes_ctrl_seq.sv
// AES sequencing controller: tracks register writes and triggers, launches
// cipher, decryption-key-generation and clear requests, owns output status.
module aes_ctrl_seq #(
  parameter int NUM_KEY_WORDS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     manual_op_i,
  input  logic                     op_i,
  input  logic                     start_i,
  input  logic                     key_clear_i,
  input  logic                     data_out_clear_i,
  input  logic [3:0]               data_in_qe_i,
  input  logic [3:0]               data_out_re_i,
  input  logic [NUM_KEY_WORDS-1:0] key_init_qe_i,
  aes_ctrl_seq_if.master           cipher,
  output logic                     data_in_prev_we_o,
  output logic                     data_out_we_o,
  output logic                     idle_o,
  output logic                     stall_o,
  output logic                     output_valid_o,
  output logic                     trigger_ack_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WAIT       = 3'd2,
    CLEAR_REQ  = 3'd3,
    CLEAR_WAIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [3:0] data_in_new_q, data_out_read_q, data_out_read_d;
  logic       key_changed_q, output_valid_q;
  logic       start_q, key_clear_q, data_out_clear_q;
  logic       dkg_q, dkg_d;
  logic       kc_sel_q, kc_sel_d, dc_sel_q, dc_sel_d;

  logic       start_cond;
  logic       data_handshake;
  logic       dkg_done;
  logic       clear_done;

  assign start_cond = manual_op_i ? start_q : (data_in_new_q == 4'hF);

  always_comb begin
    state_d                = state_q;
    dkg_d                  = dkg_q;
    kc_sel_d               = kc_sel_q;
    dc_sel_d               = dc_sel_q;
    cipher.in_valid        = 1'b0;
    cipher.out_ready       = 1'b0;
    cipher.start           = 1'b0;
    cipher.dec_key_gen     = 1'b0;
    cipher.key_clear       = 1'b0;
    cipher.data_out_clear  = 1'b0;
    data_in_prev_we_o      = 1'b0;
    data_out_we_o          = 1'b0;
    idle_o                 = 1'b0;
    stall_o                = 1'b0;
    trigger_ack_o          = 1'b0;
    data_handshake         = 1'b0;
    dkg_done               = 1'b0;
    clear_done             = 1'b0;

    case (state_q)
      IDLE: begin
        idle_o = 1'b1;
        // Clears win over a simultaneous start; start_q simply stays pending.
        if (key_clear_q || data_out_clear_q) begin
          kc_sel_d = key_clear_q;
          dc_sel_d = data_out_clear_q;
          state_d  = CLEAR_REQ;
        end else if (start_cond) begin
          dkg_d   = op_i & key_changed_q;
          state_d = START;
        end
      end
      START: begin
        cipher.in_valid    = 1'b1;
        cipher.start       = 1'b1;
        cipher.dec_key_gen = dkg_q;
        if (cipher.in_ready) begin
          // A key-generation run leaves the data start pending for a re-launch.
          if (!dkg_q) begin
            data_in_prev_we_o = 1'b1;
            data_handshake    = 1'b1;
          end
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dkg_q) begin
          cipher.out_ready = 1'b1;
          if (cipher.out_valid) begin
            dkg_done = 1'b1;
            state_d  = IDLE;
          end
        end else if (!manual_op_i && output_valid_q && (data_out_read_q != 4'hF)) begin
          stall_o = 1'b1;
        end else begin
          cipher.out_ready = 1'b1;
          if (cipher.out_valid) begin
            data_out_we_o = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      CLEAR_REQ: begin
        cipher.in_valid       = 1'b1;
        cipher.key_clear      = kc_sel_q;
        cipher.data_out_clear = dc_sel_q;
        if (cipher.in_ready) state_d = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        cipher.key_clear      = kc_sel_q;
        cipher.data_out_clear = dc_sel_q;
        cipher.out_ready      = 1'b1;
        if (cipher.out_valid) begin
          trigger_ack_o = 1'b1;
          clear_done    = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out_read_d = (data_out_read_q & ~{4{data_out_we_o}}) | data_out_re_i;
  assign output_valid_o  = output_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dkg_q   <= 1'b0;
      kc_sel_q <= 1'b0;
      dc_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dkg_q   <= dkg_d;
      kc_sel_q <= kc_sel_d;
      dc_sel_q <= dc_sel_d;
    end
  end

  // Bookkeeping: in every update below a same-cycle set beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_in_new_q    <= 4'h0;
      data_out_read_q  <= 4'h0;
      key_changed_q    <= 1'b1;
      output_valid_q   <= 1'b0;
      start_q          <= 1'b0;
      key_clear_q      <= 1'b0;
      data_out_clear_q <= 1'b0;
    end else begin
      data_in_new_q    <= (data_in_new_q & ~{4{data_handshake}}) | data_in_qe_i;
      data_out_read_q  <= data_out_read_d;
      start_q          <= (start_q & ~data_handshake) | start_i;
      key_clear_q      <= (key_clear_q & ~(clear_done & kc_sel_q)) | key_clear_i;
      data_out_clear_q <= (data_out_clear_q & ~(clear_done & dc_sel_q)) | data_out_clear_i;

      if ((|key_init_qe_i) || (clear_done && kc_sel_q)) begin
        key_changed_q <= 1'b1;
      end else if (dkg_done) begin
        key_changed_q <= 1'b0;
      end

      if (data_out_we_o) begin
        output_valid_q <= 1'b1;
      end else if ((clear_done && dc_sel_q) || (data_out_read_d == 4'hF)) begin
        output_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// Directed bench for aes_ctrl_seq with a request scoreboard and a cipher-core
// responder driven from the main sequence.
module tb_aes_ctrl_seq;
  localparam int NUM_KEY_WORDS = 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic manual_op = 1'b0, op = 1'b0, start = 1'b0, key_clear = 1'b0, dout_clear = 1'b0;
  logic [3:0] data_in_qe = 4'h0, data_out_re = 4'h0;
  logic [NUM_KEY_WORDS-1:0] key_init_qe = '0;
  logic data_in_prev_we, data_out_we, idle, stall, output_valid, trigger_ack;

  aes_ctrl_seq_if cif ();

  aes_ctrl_seq #(.NUM_KEY_WORDS(NUM_KEY_WORDS)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .manual_op_i      (manual_op),
    .op_i             (op),
    .start_i          (start),
    .key_clear_i      (key_clear),
    .data_out_clear_i (dout_clear),
    .data_in_qe_i     (data_in_qe),
    .data_out_re_i    (data_out_re),
    .key_init_qe_i    (key_init_qe),
    .cipher           (cif),
    .data_in_prev_we_o(data_in_prev_we),
    .data_out_we_o    (data_out_we),
    .idle_o           (idle),
    .stall_o          (stall),
    .output_valid_o   (output_valid),
    .trigger_ack_o    (trigger_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic start;
    logic dkg;
    logic kclr;
    logic dclr;
    logic prev_we;
    logic dout_we;
    logic ack;
  } txn_t;

  txn_t sb_q[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic st, input logic dkg, input logic kc, input logic dc,
                      input logic pwe, input logic dwe, input logic ack);
    txn_t t;
    t = '{start: st, dkg: dkg, kclr: kc, dclr: dc, prev_we: pwe, dout_we: dwe, ack: ack};
    sb_q.push_back(t);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Wait for a request, compare it with the scoreboard head, then accept it.
  task automatic accept_req(input string tag, output txn_t e, output int waited);
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      waited = i + 1;
      if (cif.in_valid) break;
    end
    chk({tag, "_req_seen"}, 32'(cif.in_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else e = '0;
    chk({tag, "_start"}, 32'(cif.start), 32'(e.start));
    chk({tag, "_dkg"}, 32'(cif.dec_key_gen), 32'(e.dkg));
    chk({tag, "_kclr"}, 32'(cif.key_clear), 32'(e.kclr));
    chk({tag, "_dclr"}, 32'(cif.data_out_clear), 32'(e.dclr));
    cif.in_ready = 1'b1; #1;
    chk({tag, "_prev_we"}, 32'(data_in_prev_we), 32'(e.prev_we));
    @(negedge clk);
    cif.in_ready = 1'b0; #1;
    chk({tag, "_valid_drop"}, 32'(cif.in_valid), 32'd0);
  endtask

  task automatic give_resp(input string tag, input txn_t e, input int lat);
    repeat (lat) @(negedge clk);
    cif.out_valid = 1'b1; #1;
    chk({tag, "_out_ready"}, 32'(cif.out_ready), 32'd1);
    chk({tag, "_dout_we"}, 32'(data_out_we), 32'(e.dout_we));
    chk({tag, "_ack"}, 32'(trigger_ack), 32'(e.ack));
    @(negedge clk);
    cif.out_valid = 1'b0; #1;
    chk({tag, "_idle_after"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t e;
    int waited;
    cif.in_ready  = 1'b0;
    cif.out_valid = 1'b0;

    // Reset state
    #12; #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_in_valid", 32'(cif.in_valid), 32'd0);
    chk("rst_out_ready", 32'(cif.out_ready), 32'd0);
    chk("rst_outputs", {26'd0, data_in_prev_we, data_out_we, stall, output_valid, trigger_ack, cif.start}, 32'd0);
    @(negedge clk); rst_ni = 1'b1;

    // Auto-mode encrypt
    manual_op = 1'b0; op = 1'b0;
    push(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_in_qe = 4'(1 << i);
    end
    @(negedge clk); data_in_qe = 4'h0; #1;
    chk("enc_not_yet", 32'(cif.in_valid), 32'd0);
    accept_req("enc", e, waited);
    chk("enc_latency", 32'(waited), 32'd1);
    give_resp("enc", e, 12);
    chk("enc_ovalid", 32'(output_valid), 32'd1);

    // Stall on unread result
    push(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_in_qe = 4'(1 << i);
    end
    @(negedge clk); data_in_qe = 4'h0;
    accept_req("stl", e, waited);
    repeat (3) @(negedge clk);
    cif.out_valid = 1'b1; #1;
    chk("stl_stall", 32'(stall), 32'd1);
    chk("stl_ready_low", 32'(cif.out_ready), 32'd0);
    chk("stl_no_we", 32'(data_out_we), 32'd0);
    chk("stl_ovalid_held", 32'(output_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_out_re = 4'(1 << i); #1;
      chk("stl_stall_reading", 32'(stall), 32'd1);
    end
    @(negedge clk); data_out_re = 4'h0; #1;
    chk("stl_released", 32'(stall), 32'd0);
    chk("stl_ready_high", 32'(cif.out_ready), 32'd1);
    chk("stl_we", 32'(data_out_we), 32'(e.dout_we));
    @(negedge clk); cif.out_valid = 1'b0; #1;
    chk("stl_ovalid_new", 32'(output_valid), 32'd1);
    chk("stl_idle", 32'(idle), 32'd1);

    // Manual decrypt after key write: key generation, then the data run
    manual_op = 1'b1; op = 1'b1;
    @(negedge clk); key_init_qe = 8'h08;
    @(negedge clk); key_init_qe = '0;
    push(1, 1, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    accept_req("dkg", e, waited);
    give_resp("dkg", e, 5);
    accept_req("dec", e, waited);
    give_resp("dec", e, 12);

    // Key clear beats a simultaneous start
    op = 1'b0;
    push(0, 0, 1, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 1, 0);
    @(negedge clk); key_clear = 1'b1; start = 1'b1;
    @(negedge clk); key_clear = 1'b0; start = 1'b0;
    accept_req("kclr", e, waited);
    give_resp("kclr", e, 3);
    accept_req("post_clr", e, waited);
    give_resp("post_clr", e, 4);

    // Data-out clear drops output_valid
    chk("dclr_ovalid_before", 32'(output_valid), 32'd1);
    push(0, 0, 0, 1, 0, 0, 1);
    @(negedge clk); dout_clear = 1'b1;
    @(negedge clk); dout_clear = 1'b0;
    accept_req("dclr", e, waited);
    give_resp("dclr", e, 2);
    chk("dclr_ovalid_after", 32'(output_valid), 32'd0);

    // Key clear re-armed key generation; after it, decrypt runs without it
    op = 1'b1;
    push(1, 1, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    accept_req("dkg2", e, waited);
    give_resp("dkg2", e, 3);
    accept_req("dec2", e, waited);
    give_resp("dec2", e, 3);
    push(1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    accept_req("dec3", e, waited);
    give_resp("dec3", e, 3);

    // Reset in WAIT re-arms key generation
    push(1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    accept_req("rstw", e, waited);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0; #1;
    chk("rstw_idle", 32'(idle), 32'd1);
    chk("rstw_enables", {28'd0, data_in_prev_we, data_out_we, cif.in_valid, cif.out_ready}, 32'd0);
    chk("rstw_status", {29'd0, stall, output_valid, trigger_ack}, 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    push(1, 1, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    accept_req("rst_dkg", e, waited);
    give_resp("rst_dkg", e, 2);
    accept_req("rst_dec", e, waited);
    give_resp("rst_dec", e, 2);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
